// File: rtl/stream_wrr_arbiter.sv
// Weighted round-robin N-to-1 stream arbiter with per-input burst quotas and lock-in.
// Optional per-input saturating transfer counters: define STREAM_WRR_ARBITER_STATS_EN.
module stream_wrr_arbiter #(
   parameter int unsigned NumInp      = 4,
   parameter int unsigned DataWidth   = 32,
   parameter type         payload_t   = logic [DataWidth-1:0],
   parameter int unsigned WeightWidth = 4,
   parameter int unsigned IdxWidth    = (NumInp > 1) ? $clog2(NumInp) : 1
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                clr_i,
   input  logic [NumInp-1:0][WeightWidth-1:0]  weight_i,
   input  payload_t                            data_i [NumInp],
   input  logic [NumInp-1:0]                   valid_i,
   output logic [NumInp-1:0]                   ready_o,
   output payload_t                            data_o,
   output logic [IdxWidth-1:0]                 idx_o,
   output logic                                valid_o,
   input  logic                                ready_i,
   output logic [NumInp-1:0][15:0]             xfer_cnt_o
);

   // Valid/ready: a beat moves on valid_o && ready_i; once valid_o is shown without
   // ready_i the selection is locked until that beat completes.
   logic [IdxWidth-1:0]    ptr;
   logic [WeightWidth-1:0] cnt;
   logic                   lock;
   logic [IdxWidth-1:0]    lock_idx;

   logic [NumInp-1:0]      elig;
   logic [IdxWidth-1:0]    sel;
   logic [IdxWidth-1:0]    sel_search;
   logic [IdxWidth-1:0]    cand;
   logic                   found;
   logic                   xfer;

   always_comb begin
      for (int unsigned i = 0; i < NumInp; i++) begin
         elig[i] = valid_i[i] && (weight_i[i] != '0);
      end
   end

   // Search starts just after ptr and wraps back to ptr itself.
   always_comb begin
      sel_search = ptr;
      found      = 1'b0;
      cand       = '0;
      for (int unsigned k = 1; k <= NumInp; k++) begin
         cand = IdxWidth'((32'(ptr) + k) % NumInp);
         if (!found && elig[cand]) begin
            sel_search = cand;
            found      = 1'b1;
         end
      end
   end

   always_comb begin
      if (lock) begin
         sel = lock_idx;
      end else if ((cnt != '0) && elig[ptr]) begin
         sel = ptr;
      end else begin
         sel = sel_search;
      end
   end

   assign valid_o = lock | (|elig);
   assign data_o  = data_i[sel];
   assign idx_o   = sel;
   assign xfer    = valid_o && ready_i;

   always_comb begin
      for (int unsigned i = 0; i < NumInp; i++) begin
         ready_o[i] = xfer && (sel == IdxWidth'(i));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr      <= IdxWidth'(NumInp - 1);
         cnt      <= '0;
         lock     <= 1'b0;
         lock_idx <= '0;
      end else if (clr_i) begin
         ptr      <= IdxWidth'(NumInp - 1);
         cnt      <= '0;
         lock     <= 1'b0;
         lock_idx <= '0;
      end else if (xfer) begin
         lock <= 1'b0;
         if ((sel == ptr) && (cnt != '0)) begin
            cnt <= cnt - WeightWidth'(1);
         end else begin
            ptr <= sel;
            cnt <= weight_i[sel] - WeightWidth'(1);
         end
      end else if (valid_o) begin
         lock     <= 1'b1;
         lock_idx <= sel;
      end
   end

`ifdef STREAM_WRR_ARBITER_STATS_EN
   for (genvar g = 0; g < NumInp; g++) begin : g_stat
      logic [15:0] xcnt;
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            xcnt <= '0;
         end else if (clr_i) begin
            xcnt <= '0;
         end else if (xfer && (sel == IdxWidth'(g)) && (xcnt != 16'hFFFF)) begin
            xcnt <= xcnt + 16'd1;
         end
      end
      assign xfer_cnt_o[g] = xcnt;
   end
`else
   assign xfer_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stream_wrr_arbiter.sv
// Bench for stream_wrr_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_stream_wrr_arbiter;
  localparam int N  = 4;
  localparam int WW = 4;
  localparam int DW = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  clr;
  logic [N-1:0][WW-1:0]  weight;
  logic [DW-1:0]         din [N];
  logic [N-1:0]          vin;
  logic [N-1:0]          rdy_o;
  logic [DW-1:0]         dout;
  logic [1:0]            idx;
  logic                  vout;
  logic                  rdy_in;
  logic [N-1:0][15:0]    xcnt;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  stream_wrr_arbiter #(.NumInp(N), .DataWidth(DW), .WeightWidth(WW)) dut (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .weight_i(weight), .data_i(din),
    .valid_i(vin), .ready_o(rdy_o), .data_o(dout), .idx_o(idx), .valid_o(vout),
    .ready_i(rdy_in), .xfer_cnt_o(xcnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner = last granted input, left = beats still owed to it, held = pending locked grant
  int           m_owner = N - 1;
  int           m_left  = 0;
  bit           m_held  = 0;
  int           m_held_idx = 0;
  int           m_stat [N] = '{default: 0};
  int           p_owner = N - 1, p_left = 0, p_held_idx = 0, p_sel = 0;
  bit           p_held = 0, p_xf = 0;
  logic [N-1:0] exp_ready = '0;

  always @(negedge clk) begin : model_cmp
    bit   el [N];
    bit   any;
    int   sel;
    bit   xf;
    int   order [$];
    bit   got;
    int   e_stat;
    any = 0;
    for (int i = 0; i < N; i++) begin
      el[i] = vin[i] && (weight[i] != 0);
      any |= el[i];
    end
    sel = m_owner;
    if (m_held) begin
      sel = m_held_idx;
      any = 1;
    end else if (m_left > 0 && el[m_owner]) begin
      sel = m_owner;
    end else begin
      order = {};
      for (int k = 1; k <= N; k++) order.push_back((m_owner + k) % N);
      got = 0;
      foreach (order[j]) if (!got && el[order[j]]) begin sel = order[j]; got = 1; end
    end
    xf = any && rdy_in;
    exp_ready = xf ? (N'(1) << sel) : '0;

    chk("valid_o", 64'(vout), 64'(any));
    chk("ready_o", 64'(rdy_o), 64'(exp_ready));
    if (any) begin
      chk("idx_o", 64'(idx), 64'(sel));
      chk("data_o", 64'(dout), 64'(din[sel]));
    end
    for (int i = 0; i < N; i++) begin
`ifdef STREAM_WRR_ARBITER_STATS_EN
      e_stat = (m_stat[i] > 65535) ? 65535 : m_stat[i];
`else
      e_stat = 0;
`endif
      chk("xfer_cnt_o", 64'(xcnt[i]), 64'(e_stat));
    end

    p_owner = m_owner; p_left = m_left; p_held = m_held; p_held_idx = m_held_idx;
    p_xf = xf; p_sel = sel;
    if (xf) begin
      p_held = 0;
      if (sel == m_owner && m_left > 0) p_left = m_left - 1;
      else begin
        p_owner = sel;
        p_left  = (int'(weight[sel]) + 15) % 16;
      end
    end else if (any) begin
      p_held = 1;
      p_held_idx = sel;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      m_owner <= N - 1; m_left <= 0; m_held <= 0; m_held_idx <= 0;
      for (int i = 0; i < N; i++) m_stat[i] <= 0;
    end else begin
      m_owner <= p_owner; m_left <= p_left; m_held <= p_held; m_held_idx <= p_held_idx;
      if (p_xf) m_stat[p_sel] <= m_stat[p_sel] + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    weight[0] = WW'(w0); weight[1] = WW'(w1); weight[2] = WW'(w2); weight[3] = WW'(w3);
  endtask

  int seq_wrr [14] = '{0,0,1,2,3,3,3,0,0,1,2,3,3,3};
  int seq_ff  [8]  = '{0,0,1,0,0,0,0,1};
  int v0_ff   [8]  = '{1,1,0,1,1,1,1,1};
  logic [DW-1:0] held_data;

  initial begin
    rst = 1'b1; clr = 1'b0; vin = '0; rdy_in = 1'b0;
    set_w(1, 1, 1, 1);
    for (int i = 0; i < N; i++) din[i] = DW'(32'hA000_0000 + i);
    @(negedge clk);
    chk("reset_valid_o", 64'(vout), 64'd0);
    chk("reset_ready_o", 64'(rdy_o), 64'd0);
    chk("reset_xfer_cnt", 64'(xcnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Weighted sequence with every input valid
    do_reset();
    set_w(2, 1, 1, 3); vin = 4'hF; rdy_in = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      chk("wrr_seq", 64'(idx), 64'(seq_wrr[c]));
      cyc();
    end

    // Lock-in while the sink stalls
    do_reset();
    set_w(1, 1, 1, 1); vin = 4'b0110; rdy_in = 1'b0;
    held_data = din[1];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("lock_idx", 64'(idx), 64'd1);
      chk("lock_data", 64'(dout), 64'(held_data));
      chk("lock_ready", 64'(rdy_o), 64'd0);
      cyc();
      if (c == 1) vin[0] = 1'b1;
    end
    rdy_in = 1'b1;
    @(negedge clk);
    chk("lock_release_idx", 64'(idx), 64'd1);
    chk("lock_release_ready", 64'(rdy_o), 64'b0010);
    cyc();
    @(negedge clk);
    chk("lock_next_idx", 64'(idx), 64'd2);
    cyc();

    // Quota forfeit and fresh quota on return
    do_reset();
    set_w(4, 1, 1, 1); vin = 4'b0010; rdy_in = 1'b1;
    for (int c = 0; c < 8; c++) begin
      vin[0] = v0_ff[c][0];
      @(negedge clk);
      chk("forfeit_seq", 64'(idx), 64'(seq_ff[c]));
      cyc();
    end

    // Zero weight masks an input
    do_reset();
    set_w(0, 2, 1, 1); vin = 4'b0011; rdy_in = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("mask_idx", 64'(idx), 64'd1);
      chk("mask_ready", 64'(rdy_o), 64'b0010);
      cyc();
    end

    // Reset in the middle of a burst on input 2
    do_reset();
    set_w(1, 1, 3, 0); vin = 4'b0111; rdy_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("burst_seq", 64'(idx), 64'((c < 2) ? c : 2));
      if (c < 3) cyc();
    end
    #1 rst = 1'b1;
    cyc();
    @(negedge clk);
    chk("rst_no_x", 64'($isunknown({vout, idx, dout, rdy_o, xcnt})), 64'd0);
    chk("rst_idx", 64'(idx), 64'd0);
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("after_rst_seq", 64'(idx), 64'(c));
      cyc();
    end

`ifdef STREAM_WRR_ARBITER_STATS_EN
    do_reset();
    set_w(1, 1, 1, 1); vin = 4'b0001; rdy_in = 1'b1;
    repeat (70000) cyc();
    @(negedge clk);
    chk("stat_sat0", 64'(xcnt[0]), 64'h FFFF);
    for (int i = 1; i < N; i++) chk("stat_other", 64'(xcnt[i]), 64'd0);
    cyc();
`else
    @(negedge clk);
    chk("stats_off", 64'(xcnt), 64'd0);
    cyc();
`endif

    // Randomized traffic; a pending beat holds valid and data until it is accepted
    do_reset();
    set_w(1, 2, 3, 4);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(vin[i] && !exp_ready[i])) begin
          vin[i] = ($urandom_range(0, 3) != 0);
          din[i] = $urandom;
        end
      end
      rdy_in = ($urandom_range(0, 9) < 7);
      clr    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) weight[$urandom_range(0, N - 1)] = WW'($urandom_range(0, 4));
      cyc();
    end
    clr = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
